// File: rtl/clock_lock_sequencer.sv
// Reset/lock sequencer for a cascade of clock-generation stages.
// Stages are released one at a time, upstream first; each is held in reset
// until every stage above it reports lock. A lock timeout re-pulses the
// current stage (bounded retries, then a sticky fault); a lock loss restarts
// from the lowest lost stage while leaving healthy upstream stages running.
//
// Handshake note: there is no valid/ready traffic here. stage_locked is a
// level input from another clock domain; it is only consumed after a 2-flop
// synchronizer, and every output is a plain registered level.
module clock_lock_sequencer #(
  parameter int N_STAGES      = 2,
  parameter int RST_PULSE     = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7,
  localparam int AW = $clog2(N_STAGES) + 1,
  localparam int RW = $clog2(MAX_RETRIES + 1)
) (
  input  logic                clk_33,
  input  logic                rst_n,
  input  logic [N_STAGES-1:0] stage_locked,
  output logic [N_STAGES-1:0] stage_rst,
  output logic                locked,
  output logic                fault,
  output logic [AW-1:0]       active_stage,
  output logic [RW-1:0]       retry_count,
  output logic [7:0]          relock_count,
  output logic [2:0]          dbg_state_o
);

  // Counter must cover the longest of the three timed intervals.
  localparam int CNT_MAX_A = (RST_PULSE > SETTLE_CYCLES) ? RST_PULSE : SETTLE_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT) ? CNT_MAX_A : LOCK_TIMEOUT;
  localparam int CW        = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] PULSE_LAST   = CW'(RST_PULSE - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [AW-1:0] LAST_STAGE   = AW'(N_STAGES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PULSE  = 3'd0,
    S_WAIT   = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       cur_q, cur_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic                locked_q, locked_d;
  logic                fault_q, fault_d;
  logic [RW-1:0]       retry_q, retry_d;
  logic [7:0]          relock_q, relock_d;

  logic [N_STAGES-1:0] sync1_q, lock_s_q;

  logic [N_STAGES-1:0] must_lock;
  logic                loss_any;
  logic [AW-1:0]       loss_idx;
  logic                cur_lock;
  logic [RW-1:0]       retry_inc;

  // Two-flop synchronizer for the asynchronous LOCKED inputs.
  always_ff @(posedge clk_33) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      lock_s_q <= '0;
    end else begin
      sync1_q  <= stage_locked;
      lock_s_q <= sync1_q;
    end
  end

  // Which stages are expected to hold lock, the lowest one that lost it, and
  // the synchronized lock of the stage currently being brought up.
  always_comb begin
    must_lock = '0;
    loss_any  = 1'b0;
    loss_idx  = '0;
    cur_lock  = 1'b0;
    for (int j = 0; j < N_STAGES; j++) begin
      if (state_q == S_SETTLE || state_q == S_RUN) begin
        must_lock[j] = 1'b1;
      end else if (state_q == S_WAIT && AW'(j) < cur_q) begin
        must_lock[j] = 1'b1;
      end
      if (AW'(j) == cur_q) begin
        cur_lock = lock_s_q[j];
      end
    end
    // Scan downward so the lowest lost index is the one that sticks.
    for (int j = N_STAGES - 1; j >= 0; j--) begin
      if (must_lock[j] && !lock_s_q[j]) begin
        loss_any = 1'b1;
        loss_idx = AW'(j);
      end
    end
  end

  assign retry_inc = retry_q + RW'(1);

  // Next-state and registered-output logic for the bring-up sequence.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    cnt_d       = cnt_q;
    stage_rst_d = stage_rst_q;
    locked_d    = locked_q;
    fault_d     = fault_q;
    retry_d     = retry_q;
    relock_d    = relock_q;

    if (loss_any) begin
      // Loss outranks advance and timeout; restart from the lowest lost stage.
      state_d  = S_PULSE;
      cur_d    = loss_idx;
      cnt_d    = '0;
      locked_d = 1'b0;
      for (int j = 0; j < N_STAGES; j++) begin
        if (AW'(j) >= loss_idx) begin
          stage_rst_d[j] = 1'b1;
        end
      end
      if (state_q == S_RUN && relock_q != 8'hFF) begin
        relock_d = relock_q + 8'd1;
      end
    end else begin
      case (state_q)
        S_PULSE: begin
          if (cnt_q == PULSE_LAST) begin
            cnt_d   = '0;
            state_d = S_WAIT;
            for (int j = 0; j < N_STAGES; j++) begin
              if (AW'(j) == cur_q) begin
                stage_rst_d[j] = 1'b0;
              end
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        S_WAIT: begin
          if (cur_lock) begin
            cnt_d = '0;
            if (cur_q == LAST_STAGE) begin
              state_d = S_SETTLE;
            end else begin
              // Downstream stage has been held in reset all along, so it is
              // released directly without a fresh pulse.
              cur_d = cur_q + AW'(1);
              for (int j = 0; j < N_STAGES; j++) begin
                if (AW'(j) == cur_q + AW'(1)) begin
                  stage_rst_d[j] = 1'b0;
                end
              end
            end
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d   = '0;
            retry_d = retry_inc;
            if (retry_inc == RETRY_LIMIT) begin
              state_d     = S_FAULT;
              stage_rst_d = '1;
              locked_d    = 1'b0;
              fault_d     = 1'b1;
            end else begin
              state_d = S_PULSE;
              for (int j = 0; j < N_STAGES; j++) begin
                if (AW'(j) == cur_q) begin
                  stage_rst_d[j] = 1'b1;
                end
              end
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d    = '0;
            state_d  = S_RUN;
            locked_d = 1'b1;
            retry_d  = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        S_RUN: begin
          locked_d = 1'b1;
        end

        S_FAULT: begin
          // Terminal until reset; lock inputs are ignored here.
          stage_rst_d = '1;
          locked_d    = 1'b0;
          fault_d     = 1'b1;
        end

        default: begin
          state_d     = S_PULSE;
          cur_d       = '0;
          cnt_d       = '0;
          stage_rst_d = '1;
          locked_d    = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; synchronous active-low reset.
  always_ff @(posedge clk_33) begin
    if (!rst_n) begin
      state_q     <= S_PULSE;
      cur_q       <= '0;
      cnt_q       <= '0;
      stage_rst_q <= '1;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
      retry_q     <= '0;
      relock_q    <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      cnt_q       <= cnt_d;
      stage_rst_q <= stage_rst_d;
      locked_q    <= locked_d;
      fault_q     <= fault_d;
      retry_q     <= retry_d;
      relock_q    <= relock_d;
    end
  end

  assign stage_rst    = stage_rst_q;
  assign locked       = locked_q;
  assign fault        = fault_q;
  assign active_stage = cur_q;
  assign retry_count  = retry_q;
  assign relock_count = relock_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_clock_lock_sequencer.sv
// Directed bench for clock_lock_sequencer with N_STAGES=2, RST_PULSE=4,
// LOCK_TIMEOUT=16, SETTLE_CYCLES=8, MAX_RETRIES=3. Each edge-by-edge
// expectation was worked out by hand from the intended behaviour.
module tb_clock_lock_sequencer;

  logic       clk_33;
  logic       rst_n;
  logic [1:0] stage_locked;
  logic [1:0] stage_rst;
  logic       locked;
  logic       fault;
  logic [1:0] active_stage;
  logic [1:0] retry_count;
  logic [7:0] relock_count;
  logic [2:0] dbg_state;

  clock_lock_sequencer #(
    .N_STAGES(2), .RST_PULSE(4), .LOCK_TIMEOUT(16),
    .SETTLE_CYCLES(8), .MAX_RETRIES(3)
  ) dut (
    .clk_33(clk_33), .rst_n(rst_n), .stage_locked(stage_locked),
    .stage_rst(stage_rst), .locked(locked), .fault(fault),
    .active_stage(active_stage), .retry_count(retry_count),
    .relock_count(relock_count), .dbg_state_o(dbg_state)
  );

  // Clock and watchdog.
  initial begin
    clk_33 = 1'b0;
    forever #5 clk_33 = ~clk_33;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish before 200000");
    $fatal(1);
  end

  // Scoreboard.
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  function automatic logic [15:0] pk(input logic [1:0] r, input logic l, input logic f,
                                     input logic [1:0] a, input logic [1:0] t,
                                     input logic [7:0] c);
    return {r, l, f, a, t, c};
  endfunction

  task automatic check(input string nm, input logic [15:0] e_in);
    logic [15:0] act;
    logic [15:0] e;
    exp_q.push_back(e_in);
    act = pk(stage_rst, locked, fault, active_stage, retry_count, relock_count);
    e = exp_q.pop_front();
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got rst=%b lkd=%b flt=%b act=%0d rty=%0d rlk=%0d, want rst=%b lkd=%b flt=%b act=%0d rty=%0d rlk=%0d",
               nm, act[15:14], act[13], act[12], act[11:10], act[9:8], act[7:0],
               e[15:14], e[13], e[12], e[11:10], e[9:8], e[7:0]);
    end
  endtask

  // Drivers: inputs change 1 time unit after the rising edge, outputs are
  // sampled at that same point.
  task automatic step(input logic [1:0] lk);
    stage_locked = lk;
    @(posedge clk_33);
    #1;
  endtask

  task automatic run_chk(input string nm, input int n, input logic [1:0] lk,
                         input logic [1:0] r, input logic l, input logic f,
                         input logic [1:0] a, input logic [1:0] t, input logic [7:0] c);
    for (int k = 0; k < n; k++) begin
      step(lk);
      check($sformatf("%s.%0d", nm, k), pk(r, l, f, a, t, c));
    end
  endtask

  task automatic do_reset(input logic [1:0] lk);
    rst_n = 1'b0;
    step(lk);
    step(lk);
    check("reset", pk(2'b11, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0));
    rst_n = 1'b1;
  endtask

  typedef struct {
    int         n;
    logic [1:0] lk;
    logic [1:0] rst;
    logic       lkd;
    logic       flt;
    logic [1:0] act;
    logic [1:0] rty;
    logic [7:0] rlk;
  } vec_t;

  vec_t tbl[18];

  initial begin
    rst_n        = 1'b0;
    stage_locked = 2'b00;

    // Nominal bring-up, loss of stage 1 in RUN, then loss of both stages.
    tbl[0]  = '{3,  2'b00, 2'b11, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0};
    tbl[1]  = '{5,  2'b00, 2'b10, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0};
    tbl[2]  = '{2,  2'b01, 2'b10, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0};
    tbl[3]  = '{5,  2'b01, 2'b00, 1'b0, 1'b0, 2'd1, 2'd0, 8'd0};
    tbl[4]  = '{10, 2'b11, 2'b00, 1'b0, 1'b0, 2'd1, 2'd0, 8'd0};
    tbl[5]  = '{3,  2'b11, 2'b00, 1'b1, 1'b0, 2'd1, 2'd0, 8'd0};
    tbl[6]  = '{2,  2'b01, 2'b00, 1'b1, 1'b0, 2'd1, 2'd0, 8'd0};
    tbl[7]  = '{4,  2'b01, 2'b10, 1'b0, 1'b0, 2'd1, 2'd0, 8'd1};
    tbl[8]  = '{4,  2'b01, 2'b00, 1'b0, 1'b0, 2'd1, 2'd0, 8'd1};
    tbl[9]  = '{10, 2'b11, 2'b00, 1'b0, 1'b0, 2'd1, 2'd0, 8'd1};
    tbl[10] = '{2,  2'b11, 2'b00, 1'b1, 1'b0, 2'd1, 2'd0, 8'd1};
    tbl[11] = '{2,  2'b00, 2'b00, 1'b1, 1'b0, 2'd1, 2'd0, 8'd1};
    tbl[12] = '{4,  2'b00, 2'b11, 1'b0, 1'b0, 2'd0, 2'd0, 8'd2};
    tbl[13] = '{1,  2'b00, 2'b10, 1'b0, 1'b0, 2'd0, 2'd0, 8'd2};
    tbl[14] = '{2,  2'b01, 2'b10, 1'b0, 1'b0, 2'd0, 2'd0, 8'd2};
    tbl[15] = '{3,  2'b01, 2'b00, 1'b0, 1'b0, 2'd1, 2'd0, 8'd2};
    tbl[16] = '{10, 2'b11, 2'b00, 1'b0, 1'b0, 2'd1, 2'd0, 8'd2};
    tbl[17] = '{2,  2'b11, 2'b00, 1'b1, 1'b0, 2'd1, 2'd0, 8'd2};

    do_reset(2'b00);
    for (int i = 0; i < 18; i++) begin
      run_chk($sformatf("vec%0d", i), tbl[i].n, tbl[i].lk, tbl[i].rst, tbl[i].lkd,
              tbl[i].flt, tbl[i].act, tbl[i].rty, tbl[i].rlk);
    end

    // From RUN: lose stage 1, re-pulse it, then reset for one edge mid-SETTLE.
    run_chk("c_pre",    2, 2'b01, 2'b00, 1'b1, 1'b0, 2'd1, 2'd0, 8'd2);
    run_chk("c_loss",   1, 2'b01, 2'b10, 1'b0, 1'b0, 2'd1, 2'd0, 8'd3);
    run_chk("c_pulse",  3, 2'b11, 2'b10, 1'b0, 1'b0, 2'd1, 2'd0, 8'd3);
    run_chk("c_wait",   1, 2'b11, 2'b00, 1'b0, 1'b0, 2'd1, 2'd0, 8'd3);
    run_chk("c_settle", 5, 2'b11, 2'b00, 1'b0, 1'b0, 2'd1, 2'd0, 8'd3);
    rst_n = 1'b0;
    step(2'b11);
    check("c_midrst", pk(2'b11, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0));
    rst_n = 1'b1;
    run_chk("c_r_pulse",  3, 2'b11, 2'b11, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
    run_chk("c_r_wait0",  1, 2'b11, 2'b10, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
    run_chk("c_r_wait1",  1, 2'b11, 2'b00, 1'b0, 1'b0, 2'd1, 2'd0, 8'd0);
    run_chk("c_r_settle", 8, 2'b11, 2'b00, 1'b0, 1'b0, 2'd1, 2'd0, 8'd0);
    run_chk("c_r_run",    1, 2'b11, 2'b00, 1'b1, 1'b0, 2'd1, 2'd0, 8'd0);

    // Stage 1 never locks: two re-pulses, then sticky fault.
    do_reset(2'b01);
    run_chk("a_pulse0", 3,  2'b01, 2'b11, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
    run_chk("a_wait0",  1,  2'b01, 2'b10, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
    run_chk("a_wait1",  16, 2'b01, 2'b00, 1'b0, 1'b0, 2'd1, 2'd0, 8'd0);
    run_chk("a_retry1", 4,  2'b01, 2'b10, 1'b0, 1'b0, 2'd1, 2'd1, 8'd0);
    run_chk("a_wait1b", 16, 2'b01, 2'b00, 1'b0, 1'b0, 2'd1, 2'd1, 8'd0);
    run_chk("a_retry2", 4,  2'b01, 2'b10, 1'b0, 1'b0, 2'd1, 2'd2, 8'd0);
    run_chk("a_wait1c", 16, 2'b01, 2'b00, 1'b0, 1'b0, 2'd1, 2'd2, 8'd0);
    run_chk("a_fault",  1,  2'b01, 2'b11, 1'b0, 1'b1, 2'd1, 2'd3, 8'd0);
    for (int i = 0; i < 8; i++) begin
      run_chk("a_hold", 1, 2'(i), 2'b11, 1'b0, 1'b1, 2'd1, 2'd3, 8'd0);
    end
    rst_n = 1'b0;
    step(2'b11);
    check("a_clear", pk(2'b11, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0));
    rst_n = 1'b1;

    // Stage 0 drops on the same edge stage 1's second timeout would fire.
    do_reset(2'b01);
    run_chk("b_pulse0", 3,  2'b01, 2'b11, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
    run_chk("b_wait0",  1,  2'b01, 2'b10, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0);
    run_chk("b_wait1",  16, 2'b01, 2'b00, 1'b0, 1'b0, 2'd1, 2'd0, 8'd0);
    run_chk("b_retry1", 4,  2'b01, 2'b10, 1'b0, 1'b0, 2'd1, 2'd1, 8'd0);
    run_chk("b_wait1b", 14, 2'b01, 2'b00, 1'b0, 1'b0, 2'd1, 2'd1, 8'd0);
    run_chk("b_drop",   2,  2'b00, 2'b00, 1'b0, 1'b0, 2'd1, 2'd1, 8'd0);
    run_chk("b_loss",   1,  2'b00, 2'b11, 1'b0, 1'b0, 2'd0, 2'd1, 8'd0);
    run_chk("b_pulse",  3,  2'b00, 2'b11, 1'b0, 1'b0, 2'd0, 2'd1, 8'd0);
    run_chk("b_wait0b", 1,  2'b00, 2'b10, 1'b0, 1'b0, 2'd0, 2'd1, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
